// File: rtl/text_console_writer_if.sv
// Write-only bus from the console writer to the text-mode screenbuffer.
// Master holds addr/wdata/wmask/wen until the slave returns ready.
interface text_console_writer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ready;

    modport master (output addr, output wdata, output wmask, output wen, input ready);
    modport slave  (input addr, input wdata, input wmask, input wen, output ready);
endinterface

// File: rtl/text_console_writer.sv
// Console byte stream to 80x30 text screenbuffer writer: cursor tracking,
// CR/LF/BS/FF handling, right-edge wrap and ring scroll with row clear.
module text_console_writer #(
    parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h10000,
    parameter int unsigned COLS                   = 80,
    parameter int unsigned ROWS                   = 30,
    parameter logic [7:0]  CLEAR_CHAR             = 8'h20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  char_in,
    input  logic                        char_valid,
    output logic                        char_ready,
    text_console_writer_if.master       bus,
    output logic [6:0]                  cursor_col,
    output logic [4:0]                  cursor_row,
    output logic                        busy
);

    localparam int unsigned IDX_W        = $clog2(COLS * ROWS);
    localparam int unsigned LINE_WORDS   = COLS / 4;
    localparam int unsigned SCREEN_WORDS = (COLS * ROWS) / 4;
    localparam int unsigned WCNT_W       = $clog2(SCREEN_WORDS);
    localparam logic [WCNT_W-1:0] LINE_LAST   = WCNT_W'(LINE_WORDS - 1);
    localparam logic [WCNT_W-1:0] SCREEN_LAST = WCNT_W'(SCREEN_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE_CHAR,
        S_CLEAR_LINE,
        S_CLEAR_SCREEN
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    row_base_q, row_base_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                adv_q, adv_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;
    logic                wen_q, wen_d;
    logic                char_ready_q, char_ready_d;
    logic                busy_q, busy_d;

    logic                accept, wr_done, row_adv, at_last_row, issue;
    logic [31:0]         issue_addr, issue_data, clr_base;
    logic [3:0]          issue_mask;
    logic [WCNT_W-1:0]   clr_last;
    logic [4:0]          row_nxt;
    logic [IDX_W-1:0]    rb_nxt;

    assign bus.addr   = addr_q;
    assign bus.wdata  = wdata_q;
    assign bus.wmask  = wmask_q;
    assign bus.wen    = wen_q;
    assign char_ready = char_ready_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CLEAR_SCREEN;
            col_q        <= '0;
            row_q        <= '0;
            idx_q        <= '0;
            row_base_q   <= '0;
            wcnt_q       <= '0;
            adv_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wen_q        <= 1'b0;
            char_ready_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            row_base_q   <= row_base_d;
            wcnt_q       <= wcnt_d;
            adv_q        <= adv_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            wen_q        <= wen_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, cursor and bus-request logic; a new write is launched via 'issue'.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        idx_d      = idx_q;
        row_base_d = row_base_q;
        wcnt_d     = wcnt_q;
        adv_d      = adv_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        wen_d      = wen_q;
        issue      = 1'b0;
        issue_addr = '0;
        issue_data = '0;
        issue_mask = '0;
        row_adv    = 1'b0;

        accept      = char_valid & char_ready_q;
        wr_done     = wen_q & bus.ready;
        at_last_row = (row_q == 5'(ROWS - 1));
        row_nxt     = at_last_row ? '0 : row_q + 5'd1;
        rb_nxt      = at_last_row ? '0 : row_base_q + IDX_W'(COLS);
        clr_base    = (state_q == S_CLEAR_LINE) ? SCREENBUFFER_BASE_ADDR + 32'(row_base_q)
                                                : SCREENBUFFER_BASE_ADDR;
        clr_last    = (state_q == S_CLEAR_LINE) ? LINE_LAST : SCREEN_LAST;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (char_in >= 8'h20 && char_in != 8'h7F) begin
                        issue      = 1'b1;
                        issue_addr = SCREENBUFFER_BASE_ADDR + 32'(idx_q);
                        issue_data = {4{char_in}};
                        issue_mask = 4'b0001 << idx_q[1:0];
                        adv_d      = 1'b1;
                        state_d    = S_WRITE_CHAR;
                    end else begin
                        case (char_in)
                            8'h0D: begin
                                col_d = '0;
                                idx_d = row_base_q;
                            end
                            8'h0A: row_adv = 1'b1;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d      = col_q - 7'd1;
                                    idx_d      = idx_q - IDX_W'(1);
                                    issue      = 1'b1;
                                    issue_addr = SCREENBUFFER_BASE_ADDR + 32'(idx_d);
                                    issue_data = {4{CLEAR_CHAR}};
                                    issue_mask = 4'b0001 << idx_d[1:0];
                                    adv_d      = 1'b0;
                                    state_d    = S_WRITE_CHAR;
                                end
                            end
                            8'h0C: begin
                                col_d      = '0;
                                row_d      = '0;
                                idx_d      = '0;
                                row_base_d = '0;
                                wcnt_d     = '0;
                                state_d    = S_CLEAR_SCREEN;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_WRITE_CHAR: begin
                if (wr_done) begin
                    wen_d = 1'b0;
                    if (adv_q && col_q == 7'(COLS - 1)) begin
                        row_adv = 1'b1;
                    end else begin
                        if (adv_q) begin
                            col_d = col_q + 7'd1;
                            idx_d = idx_q + IDX_W'(1);
                        end
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR_LINE, S_CLEAR_SCREEN: begin
                // First word launches from an idle bus; the rest follow back-to-back.
                if (!wen_q) begin
                    issue      = 1'b1;
                    issue_addr = clr_base + (32'(wcnt_q) << 2);
                    issue_data = {4{CLEAR_CHAR}};
                    issue_mask = 4'hF;
                end else if (wr_done) begin
                    if (wcnt_q == clr_last) begin
                        wen_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                        addr_d = addr_q + 32'd4;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (row_adv) begin
            col_d      = '0;
            row_d      = row_nxt;
            row_base_d = rb_nxt;
            idx_d      = rb_nxt;
            wcnt_d     = '0;
            state_d    = S_CLEAR_LINE;
        end

        if (issue) begin
            addr_d  = issue_addr;
            wdata_d = issue_data;
            wmask_d = issue_mask;
            wen_d   = 1'b1;
        end

        char_ready_d = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: screen model + write scoreboard.
module tb_text_console_writer;

    localparam logic [31:0] BASE  = 32'h10000;
    localparam logic [31:0] BLANK = 32'h20202020;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    text_console_writer_if bus();

    text_console_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .bus        (bus),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_q[$];
    int          m_col = 0;
    int          m_row = 0;
    int          ready_mode = 0;
    int          wr_count = 0;
    logic [31:0] first_addr, last_addr, last_data;
    logic [3:0]  last_mask;

    // Ready changes shortly after posedge so it is stable at the monitor's negedge.
    initial bus.ready = 1'b1;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.ready = 1'b1;
            1:       bus.ready = ($urandom_range(3) != 0);
            default: bus.ready = 1'b0;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic void push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_t w;
        w.a = a; w.d = d; w.m = m;
        exp_q.push_back(w);
    endfunction

    function automatic void m_clear_screen();
        m_col = 0;
        m_row = 0;
        for (int k = 0; k < 600; k++) push_wr(BASE + 32'(4 * k), BLANK, 4'hF);
    endfunction

    function automatic void m_row_adv();
        m_col = 0;
        m_row = (m_row == 29) ? 0 : m_row + 1;
        for (int k = 0; k < 20; k++) push_wr(BASE + 32'(m_row * 80 + 4 * k), BLANK, 4'hF);
    endfunction

    function automatic void model_byte(input logic [7:0] c);
        int idx;
        idx = m_row * 80 + m_col;
        if ((c >= 8'h20 && c <= 8'h7E) || c >= 8'h80) begin
            push_wr(BASE + 32'(idx), {4{c}}, 4'b0001 << (idx % 4));
            if (m_col < 79) m_col++;
            else m_row_adv();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            m_row_adv();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(BASE + 32'(idx - 1), BLANK, 4'b0001 << ((idx - 1) % 4));
            end
        end else if (c == 8'h0C) begin
            m_clear_screen();
        end
    endfunction

    // ---------------- bus monitor / scoreboard ----------------
    logic        pend = 1'b0;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_mask;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                tests++;
                if (bus.wen !== 1'b1 || bus.addr !== h_addr || bus.wdata !== h_data || bus.wmask !== h_mask) begin
                    fails++;
                    $display("FAIL bus_hold: got wen=%b addr=%h data=%h mask=%h, want wen=1 addr=%h data=%h mask=%h",
                             bus.wen, bus.addr, bus.wdata, bus.wmask, h_addr, h_data, h_mask);
                end
            end
            if (bus.wen === 1'b1 && bus.ready === 1'b1) begin
                wr_t e;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_write: got unexpected addr=%h data=%h mask=%h, want no write",
                             bus.addr, bus.wdata, bus.wmask);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.addr !== e.a || bus.wdata !== e.d || bus.wmask !== e.m) begin
                        fails++;
                        $display("FAIL bus_write: got addr=%h data=%h mask=%h, want addr=%h data=%h mask=%h",
                                 bus.addr, bus.wdata, bus.wmask, e.a, e.d, e.m);
                    end
                end
                if (wr_count == 0) first_addr = bus.addr;
                wr_count++;
                last_addr = bus.addr;
                last_data = bus.wdata;
                last_mask = bus.wmask;
                pend = 1'b0;
            end else if (bus.wen === 1'b1) begin
                pend   = 1'b1;
                h_addr = bus.addr;
                h_data = bus.wdata;
                h_mask = bus.wmask;
            end else begin
                pend = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        while (char_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got char_ready=%b, want 1 within 20000 cycles", char_ready);
        end else begin
            model_byte(c);
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(char_ready === 1'b1 && busy === 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=%b char_ready=%b, want idle", busy, char_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.wen !== 1'b0 || bus.addr !== 32'h0 || bus.wdata !== 32'h0 || bus.wmask !== 4'h0 ||
            char_ready !== 1'b0 || busy !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            fails++;
            $display("FAIL reset_values: got wen=%b addr=%h wdata=%h wmask=%h rdy=%b busy=%b cur=(%0d,%0d), want 0,0,0,0,0,1,(0,0)",
                     bus.wen, bus.addr, bus.wdata, bus.wmask, char_ready, busy, cursor_col, cursor_row);
        end
        exp_q.delete();
        m_clear_screen();
        wr_count = 0;
        rst_n = 1'b1;
        wait_idle();
        tests++;
        if (wr_count != 600 || exp_q.size() != 0 || first_addr !== 32'h10000 || last_addr !== 32'h1095C) begin
            fails++;
            $display("FAIL reset_clear: got writes=%0d pending=%0d first=%h last=%h, want 600 0 10000 1095c",
                     wr_count, exp_q.size(), first_addr, last_addr);
        end
        tests++;
        if (char_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            fails++;
            $display("FAIL reset_idle: got rdy=%b cur=(%0d,%0d), want 1 (0,0)", char_ready, cursor_col, cursor_row);
        end
    endtask

    task automatic test_ab();
        send_byte(8'h41);
        tests++;
        if (bus.wen !== 1'b1 || char_ready !== 1'b0 || bus.addr !== 32'h10000 ||
            bus.wmask !== 4'b0001 || bus.wdata !== 32'h41414141) begin
            fails++;
            $display("FAIL ab_first: got wen=%b rdy=%b addr=%h mask=%b data=%h, want 1 0 10000 0001 41414141",
                     bus.wen, char_ready, bus.addr, bus.wmask, bus.wdata);
        end
        @(negedge clk);
        tests++;
        if (bus.wen !== 1'b0 || char_ready !== 1'b1) begin
            fails++;
            $display("FAIL ab_latency: got wen=%b rdy=%b, want wen=0 rdy=1", bus.wen, char_ready);
        end
        send_byte(8'h42);
        wait_idle();
        tests++;
        if (last_addr !== 32'h10001 || last_mask !== 4'b0010 || last_data !== 32'h42424242 ||
            cursor_col !== 7'd2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL ab_second: got addr=%h mask=%b data=%h col=%0d pending=%0d, want 10001 0010 42424242 2 0",
                     last_addr, last_mask, last_data, cursor_col, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        send_byte(8'h0D);
        for (int i = 0; i < 80; i++) send_byte(8'($urandom_range(8'h21, 8'h7E)));
        wait_idle();
        tests++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd1 || last_addr !== 32'h1009C || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap: got cur=(%0d,%0d) last=%h pending=%0d, want (0,1) 1009c 0",
                     cursor_col, cursor_row, last_addr, exp_q.size());
        end
    endtask

    task automatic test_lf_bottom();
        for (int i = 0; i < 28; i++) send_byte(8'h0A);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(8'h80, 8'hFF)));
        wait_idle();
        tests++;
        if (cursor_col !== 7'd3 || cursor_row !== 5'd29) begin
            fails++;
            $display("FAIL lf_setup: got cur=(%0d,%0d), want (3,29)", cursor_col, cursor_row);
        end
        send_byte(8'h0A);
        wait_idle();
        tests++;
        if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || last_addr !== 32'h1004C || exp_q.size() != 0) begin
            fails++;
            $display("FAIL lf_scroll: got cur=(%0d,%0d) last=%h pending=%0d, want (0,0) 1004c 0",
                     cursor_col, cursor_row, last_addr, exp_q.size());
        end
    endtask

    task automatic test_bs();
        int snap;
        snap = wr_count;
        send_byte(8'h08);
        wait_idle();
        tests++;
        if (wr_count != snap || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            fails++;
            $display("FAIL bs_col0: got writes=%0d cur=(%0d,%0d), want %0d (0,0)", wr_count, cursor_col, cursor_row, snap);
        end
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
        send_byte(8'h08);
        wait_idle();
        tests++;
        if (last_addr !== 32'h10004 || last_mask !== 4'b0001 || last_data !== BLANK ||
            cursor_col !== 7'd4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bs_erase: got addr=%h mask=%b data=%h col=%0d pending=%0d, want 10004 0001 20202020 4 0",
                     last_addr, last_mask, last_data, cursor_col, exp_q.size());
        end
        snap = wr_count;
        send_byte(8'h07);
        wait_idle();
        tests++;
        if (wr_count != snap || cursor_col !== 7'd4 || cursor_row !== 5'd0) begin
            fails++;
            $display("FAIL bell_drop: got writes=%0d cur=(%0d,%0d), want %0d (4,0)", wr_count, cursor_col, cursor_row, snap);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, d;
        logic [3:0]  m;
        int          bad = 0;
        ready_mode = 2;
        repeat (2) @(negedge clk);
        send_byte(8'h5A);
        a = bus.addr; d = bus.wdata; m = bus.wmask;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wen !== 1'b1 || bus.addr !== a || bus.wdata !== d || bus.wmask !== m || char_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || a !== 32'h10004 || m !== 4'b0001 || d !== 32'h5A5A5A5A) begin
            fails++;
            $display("FAIL stall_hold: got %0d unstable cycles addr=%h data=%h mask=%b, want 0 10004 5a5a5a5a 0001",
                     bad, a, d, m);
        end
        ready_mode = 0;
        wait_idle();
        tests++;
        if (cursor_col !== 7'd5 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_done: got col=%0d pending=%0d, want 5 0", cursor_col, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        int         r;
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            if (r < 70) begin
                c = 8'($urandom_range(8'h20, 8'hFF));
                if (c == 8'h7F) c = 8'h41;
            end else if (r < 78) c = 8'h0D;
            else if (r < 86) c = 8'h0A;
            else if (r < 94) c = 8'h08;
            else if (r < 99) begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h7F;
            end else c = 8'h0C;
            send_byte(c);
        end
        ready_mode = 0;
        wait_idle();
        tests++;
        if (cursor_col !== 7'(m_col) || cursor_row !== 5'(m_row) || exp_q.size() != 0) begin
            fails++;
            $display("FAIL random_stream: got cur=(%0d,%0d) pending=%0d, want (%0d,%0d) 0",
                     cursor_col, cursor_row, exp_q.size(), m_col, m_row);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ready_mode = 0;
        send_byte(8'h0A);
        repeat (3) @(negedge clk);
        while (bus.wen !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.wen !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid: got wen=%b rdy=%b busy=%b cur=(%0d,%0d), want 0 0 1 (0,0)",
                     bus.wen, char_ready, busy, cursor_col, cursor_row);
        end
        exp_q.delete();
        m_clear_screen();
        repeat (2) @(negedge clk);
        wr_count = 0;
        rst_n = 1'b1;
        wait_idle();
        tests++;
        if (wr_count != 600 || first_addr !== 32'h10000 || last_addr !== 32'h1095C || exp_q.size() != 0) begin
            fails++;
            $display("FAIL reset_restart: got writes=%0d first=%h last=%h pending=%0d, want 600 10000 1095c 0",
                     wr_count, first_addr, last_addr, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ab();
        test_wrap();
        test_lf_bottom();
        test_bs();
        test_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion by 3000000, want finish");
        $fatal(1);
    end

endmodule
